button_debounce: RTL and testbench

Debounces and synchronizes one raw mechanical push-button input into a clean, glitch-free, active-high level. It sits directly upstream of the button synchronizer (one-shot pulse generator) in ProjectB. Its `Bo` drives that stage's `Bi`. Each physical press therefore yields exactly one clean high level, even with contact bounce or metastable sampling of the asynchronous pin.

---
 rtl/button_debounce.sv | 79 +++++++
 tb/tb_button_debounce.sv | 129 ++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Debounces one raw push-button pin into a clean active-high pressed level.
// Two-flop synchronizer, then a 4-state confirm FSM with a hold counter.
module button_debounce #(
  parameter int CNT_MAX    = 500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Bi,
  output logic Bo
);

  localparam int             CW   = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  LAST = CW'(CNT_MAX - 1);
  localparam logic           REL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    PRESSED   = 2'b10,
    RELEASING = 2'b11
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s1, s2, lvl;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1 <= REL;
      s2 <= REL;
    end else begin
      s1 <= Bi;
      s2 <= s1;
    end
  end

  assign lvl = (ACTIVE_LOW != 0) ? ~s2 : s2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Any opposite-level sample inside a candidate window drops back to the
  // confirmed state, so the window restarts from zero on the next attempt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (lvl) state_nxt = ARMING;
      end
      ARMING: begin
        if (!lvl)             state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = PRESSED;
        else                  cnt_nxt   = cnt + CW'(1);
      end
      PRESSED: begin
        if (!lvl) state_nxt = RELEASING;
      end
      RELEASING: begin
        if (lvl)              state_nxt = PRESSED;
        else if (cnt == LAST) state_nxt = IDLE;
        else                  cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so no glitch path from the pin.
  assign Bo = (state == PRESSED) || (state == RELEASING);

endmodule

// File: tb/tb_button_debounce.sv
// Randomized + directed bench for button_debounce (CNT_MAX=4 and CNT_MAX=1),
// scoreboard queues fed by a run-length reference model.
module tb_button_debounce;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Bi    = 1'b1;
  logic bo4, bo1;

  always #5 Clock = ~Clock;

  button_debounce #(.CNT_MAX(4), .ACTIVE_LOW(1)) dut4 (
    .Clock(Clock), .Reset(Reset), .Bi(Bi), .Bo(bo4));
  button_debounce #(.CNT_MAX(1), .ACTIVE_LOW(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Bi(Bi), .Bo(bo1));

  int total = 0;
  int bad   = 0;
  bit q4[$];
  bit q1[$];

  // Model: the level judged at an edge is the pin as sampled two edges
  // earlier; Bo flips once CNT_MAX+1 consecutive judgements disagree with it.
  bit h1 = 1'b0, h2 = 1'b0;
  int run4 = 0, run1 = 0;
  bit m4 = 1'b0, m1 = 1'b0;

  task automatic judge(input bit obs, input int cm, inout int run, inout bit bo);
    if (obs != bo) begin
      run++;
      if (run == cm + 1) begin
        bo  = ~bo;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step(input bit rst, input bit bi);
    @(negedge Clock);
    #1;
    Reset = rst;
    Bi    = bi;
    if (rst) begin
      h1 = 0; h2 = 0; run4 = 0; run1 = 0; m4 = 0; m1 = 0;
    end else begin
      judge(h2, 4, run4, m4);
      judge(h2, 1, run1, m1);
      h2 = h1;
      h1 = (bi == 1'b0);
    end
    q4.push_back(m4);
    q1.push_back(m1);
  endtask

  task automatic hold(input bit rst, input bit bi, input int n);
    for (int i = 0; i < n; i++) step(rst, bi);
  endtask

  always @(negedge Clock) begin
    if (q4.size() != 0) begin
      bit e;
      e = q4.pop_front();
      total++;
      if (bo4 !== e) begin
        bad++;
        $display("FAIL bo_cnt4 t=%0t got=%b want=%b", $time, bo4, e);
      end
    end
    if (q1.size() != 0) begin
      bit e;
      e = q1.pop_front();
      total++;
      if (bo1 !== e) begin
        bad++;
        $display("FAIL bo_cnt1 t=%0t got=%b want=%b", $time, bo1, e);
      end
    end
  end

  initial begin
    // reset held with pin pressed, then released with pin still pressed
    hold(1, 0, 2);
    hold(0, 0, 10);
    // clean release and press
    hold(0, 1, 10);
    hold(0, 0, 10);
    hold(0, 1, 10);
    // bounce rejection
    step(0, 0); step(0, 1); step(0, 0); step(0, 0); step(0, 1);
    step(0, 0); step(0, 0); step(0, 0); step(0, 1);
    hold(0, 1, 8);
    // bounce then settle
    step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    hold(0, 0, 10);
    // release glitches while pressed
    step(0, 1);
    hold(0, 0, 6);
    hold(0, 1, 3);
    hold(0, 0, 8);
    // reset mid-window, then continuous press
    hold(0, 1, 10);
    hold(0, 0, 4);
    hold(1, 0, 1);
    hold(0, 0, 10);
    // short presses for the CNT_MAX=1 instance
    hold(0, 1, 6);
    step(0, 0);
    hold(0, 1, 6);
    hold(0, 0, 2);
    hold(0, 1, 6);
    // randomized bouncing segments with occasional resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 24) == 0) step(1, 1'($urandom_range(0, 1)));
      else hold(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    end
    hold(0, 1, 10);
    repeat (2) @(negedge Clock);
    #2;
    if (q4.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain q4=%0d q1=%0d want=0", q4.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
